// File: rtl/program_loader.sv
// Streams a byte-serial program image (header, instruction words, data words) into the
// processor's load port, then enables execution.
module program_loader #(
  parameter int unsigned MAX_INSTR = 1024,
  parameter int unsigned MAX_DATA  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] new_instruction,
  output logic        word_valid,
  output logic [15:0] load_addr,
  output logic        add_into,
  output logic        start_signal,
  output logic        err
);

  typedef enum logic [2:0] {
    StHdr    = 3'd0,
    StInstr  = 3'd1,
    StSwitch = 3'd2,
    StData   = 3'd3,
    StDone   = 3'd4,
    StErr    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] n_i_q, n_i_d;
  logic [15:0] n_d_q, n_d_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] addr_q, addr_d;
  logic        word_valid_q, word_valid_d;
  logic        add_into_q, add_into_d;
  logic        start_q, start_d;
  logic        err_q, err_d;

  logic        xfer;
  logic        last_byte;
  logic [15:0] hdr_ni;
  logic [15:0] hdr_nd;
  logic [15:0] word_limit;

  // Gated by reset so the loader never advertises readiness while held in reset.
  assign in_ready  = reset & ((state_q == StHdr) | (state_q == StInstr) | (state_q == StData));
  assign xfer      = in_valid & in_ready;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign hdr_ni    = shift_q[23:8];
  assign hdr_nd    = {shift_q[7:0], in_byte};
  assign word_limit = (state_q == StInstr) ? n_i_q : n_d_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    n_i_d        = n_i_q;
    n_d_d        = n_d_q;
    word_idx_d   = word_idx_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    word_valid_d = 1'b0;
    add_into_d   = add_into_q;
    start_d      = start_q;
    err_d        = err_q;

    case (state_q)
      StHdr: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_byte};
          if (last_byte) begin
            n_i_d = hdr_ni;
            n_d_d = hdr_nd;
            if ((32'(hdr_ni) > MAX_INSTR) || (32'(hdr_nd) > MAX_DATA)) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else if (hdr_ni != 16'd0) begin
              state_d = StInstr;
            end else if (hdr_nd != 16'd0) begin
              state_d = StSwitch;
            end else begin
              state_d = StDone;
            end
          end
        end
      end

      StInstr, StData: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_byte};
          if (last_byte) begin
            instr_d      = {shift_q, in_byte};
            addr_d       = word_idx_q;
            word_valid_d = 1'b1;
            word_idx_d   = word_idx_q + 16'd1;
            if (word_idx_q == word_limit - 16'd1) begin
              if (state_q == StInstr && n_d_q != 16'd0) begin
                state_d = StSwitch;
              end else begin
                state_d = StDone;
              end
            end
          end
        end
      end

      StSwitch: begin
        state_d    = StData;
        add_into_d = 1'b1;
        word_idx_d = 16'd0;
      end

      StDone: start_d = 1'b1;

      StErr: ;

      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StHdr;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      n_i_q        <= 16'd0;
      n_d_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      instr_q      <= 32'd0;
      addr_q       <= 16'd0;
      word_valid_q <= 1'b0;
      add_into_q   <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      n_i_q        <= n_i_d;
      n_d_q        <= n_d_d;
      word_idx_q   <= word_idx_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      word_valid_q <= word_valid_d;
      add_into_q   <= add_into_d;
      start_q      <= start_d;
      err_q        <= err_d;
    end
  end

  assign new_instruction = instr_q;
  assign load_addr       = addr_q;
  assign word_valid      = word_valid_q;
  assign add_into        = add_into_q;
  assign start_signal    = start_q;
  assign err             = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected load-port writes are queued as bytes are
// driven and compared whenever word_valid pulses.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] new_instruction;
  logic        word_valid;
  logic [15:0] load_addr;
  logic        add_into;
  logic        start_signal;
  logic        err;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [48:0] exp_q[$];
  logic [48:0] exp_e;

  program_loader #(
    .MAX_INSTR(1024),
    .MAX_DATA (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_byte        (in_byte),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .new_instruction(new_instruction),
    .word_valid     (word_valid),
    .load_addr      (load_addr),
    .add_into       (add_into),
    .start_signal   (start_signal),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Every pulse must match the oldest queued expectation; a pulse with nothing queued fails.
  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got addr=%0d word=%h add_into=%b, required no pulse",
                 load_addr, new_instruction, add_into);
      end else begin
        exp_e = exp_q.pop_front();
        if ({load_addr, new_instruction, add_into} !== exp_e) begin
          errors++;
          $display("FAIL word_pulse: got addr=%0d word=%h add_into=%b, required addr=%0d word=%h add_into=%b",
                   load_addr, new_instruction, add_into, exp_e[48:33], exp_e[32:1], exp_e[0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: got in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      if (i != 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [31:0] w, input logic ai);
    exp_q.push_back({a, w, ai});
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, word_valid, add_into, start_signal, err, new_instruction, load_addr} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wv=%b ai=%b st=%b err=%b word=%h addr=%0d, required all 0",
               in_ready, word_valid, add_into, start_signal, err, new_instruction, load_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    push_exp(16'd0, 32'h20DB000A, 1'b0);
    send_word(32'h20DB000A, 0);
    push_exp(16'd1, 32'h04DA000B, 1'b0);
    send_word(32'h04DA000B, 0);
    checks++;
    if (in_ready !== 1'b0 || add_into !== 1'b0) begin
      errors++;
      $display("FAIL switch_cycle: got in_ready=%b add_into=%b, required 0 0", in_ready, add_into);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || add_into !== 1'b1) begin
      errors++;
      $display("FAIL data_entry: got in_ready=%b add_into=%b, required 1 1", in_ready, add_into);
    end
    push_exp(16'd0, 32'h00000283, 1'b1);
    send_word(32'h00000283, 0);
    checks++;
    if (start_signal !== 1'b0) begin
      errors++;
      $display("FAIL start_early: got %b, required 0 during last pulse", start_signal);
    end
    @(negedge clk);
    checks++;
    if (start_signal !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_b2b: got start=%b in_ready=%b, required 1 0", start_signal, in_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: got %0d undelivered words, required 0", exp_q.size());
    end
  endtask

  task automatic test_empty_header();
    int p0;
    do_reset();
    p0 = pulses;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (start_signal !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL empty_hdr_edge: got start=%b in_ready=%b, required 0 0", start_signal, in_ready);
    end
    @(negedge clk);
    checks++;
    if (start_signal !== 1'b1 || add_into !== 1'b0 || pulses != p0) begin
      errors++;
      $display("FAIL empty_hdr: got start=%b add_into=%b pulses=%0d, required 1 0 0",
               start_signal, add_into, pulses - p0);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h04); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || start_signal !== 1'b0) begin
      errors++;
      $display("FAIL oversize: got err=%b in_ready=%b start=%b, required 1 0 0",
               err, in_ready, start_signal);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_byte = 8'(i + 8'hA0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || start_signal !== 1'b0 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_terminal: got err=%b in_ready=%b start=%b wv=%b, required 1 0 0 0",
               err, in_ready, start_signal, word_valid);
    end
  endtask

  task automatic test_stalled_word();
    int p0;
    do_reset();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    p0 = pulses;
    push_exp(16'd0, 32'hCAFE5A7E, 1'b0);
    send_word(32'hCAFE5A7E, 3);
    @(negedge clk);
    checks++;
    if (pulses - p0 != 1 || start_signal !== 1'b1 || add_into !== 1'b0) begin
      errors++;
      $display("FAIL stalled_word: got pulses=%0d start=%b add_into=%b, required 1 1 0",
               pulses - p0, start_signal, add_into);
    end
    checks++;
    if (new_instruction !== 32'hCAFE5A7E || load_addr !== 16'd0) begin
      errors++;
      $display("FAIL word_hold: got word=%h addr=%0d, required cafe5a7e 0",
               new_instruction, load_addr);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    push_exp(16'd0, 32'hDEADBEEF, 1'b0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h55); send_byte(8'h66);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, word_valid, add_into, start_signal, err, new_instruction, load_addr} !== 53'd0) begin
      errors++;
      $display("FAIL midload_reset: got rdy=%b wv=%b ai=%b st=%b err=%b word=%h addr=%0d, required all 0",
               in_ready, word_valid, add_into, start_signal, err, new_instruction, load_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    push_exp(16'd0, 32'h11223344, 1'b0);
    send_word(32'h11223344, 0);
    @(negedge clk);
    checks++;
    if (start_signal !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload: got start=%b pending=%0d, required 1 0", start_signal, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_empty_header();
    test_oversize();
    test_stalled_word();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MAX_INSTR, default 1024, meaning the largest accepted instruction-word count.
REQ-002 SHALL have parameter MAX_DATA, default 1024, meaning the largest accepted data-word count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_byte  input  8  incoming program byte.
REQ-006 SHALL have port in_valid  input  1  in_byte is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port new_instruction  output  32  assembled word presented to the processor load port.
REQ-009 SHALL have port word_valid  output  1  one-cycle write enable for new_instruction; the processor load port writes only when this is high.
REQ-010 SHALL have port load_addr  output  16  index of the presented word within its target memory.
REQ-011 SHALL have port add_into  output  1  0 = instruction memory target, 1 = data memory target.
REQ-012 SHALL have port start_signal  output  1  program execution enable to the processor.
REQ-013 SHALL have port err  output  1  header rejected; loader halted.

Function
REQ-014 SHALL implement states HDR, INSTR, SWITCH, DATA, DONE, ERR.
REQ-015 Byte transfer SHALL occur only on a rising edge where in_valid and in_ready are both high.
REQ-016 in_ready SHALL be high in HDR, INSTR and DATA, and low in SWITCH, DONE and ERR.
REQ-017 HDR SHALL accept 4 bytes: instruction count N_I (16 bit, big-endian), then data count N_D (16 bit, big-endian).
REQ-018 After the 4th header byte, next state SHALL be: ERR if N_I > MAX_INSTR or N_D > MAX_DATA; else INSTR if N_I > 0; else SWITCH if N_D > 0; else DONE.
REQ-019 Words SHALL be assembled from 4 accepted bytes, big-endian (first byte = bits 31:24).
REQ-020 On the edge accepting a word's 4th byte, the loader SHALL register new_instruction, register load_addr = word index (0-based, per memory), and set word_valid high for exactly the following cycle.
REQ-021 new_instruction and load_addr SHALL hold their values until the next word is registered.
REQ-022 Accepting the 4th byte of word N_I-1 in INSTR SHALL move to SWITCH if N_D > 0, else to DONE.
REQ-023 SWITCH SHALL last exactly one cycle; add_into SHALL go high on the edge leaving SWITCH; next state DATA; word index SHALL reset to 0.
REQ-024 Accepting the 4th byte of word N_D-1 in DATA SHALL move to DONE.
REQ-025 start_signal SHALL go high on the first edge in DONE, i.e. one cycle after the final word_valid pulse (or one cycle after the header when N_I = N_D = 0), and SHALL stay high until reset.
REQ-026 DONE and ERR SHALL be terminal; in_valid SHALL be ignored there.
REQ-027 err SHALL go high on entry to ERR and stay high; start_signal SHALL stay low in ERR.
REQ-028 Gaps in in_valid SHALL stall assembly without losing partial-word bytes.
REQ-029 add_into SHALL remain 0 throughout when N_D = 0.

Reset
REQ-030 Asserting reset low SHALL immediately force state HDR, byte counter 0, word index 0, new_instruction 0, load_addr 0, word_valid 0, add_into 0, start_signal 0, err 0.
REQ-031 Reset mid-load SHALL discard all partial header and word bytes; the next load restarts at the header.
REQ-032 in_ready SHALL be low while reset is low and go high in the first cycle after release.

Verification
REQ-033 Header 00 02 00 01, words 20DB000A, 04DA000B, 00000283 streamed back-to-back -> word_valid pulses with (addr, word, add_into) = (0, 20DB000A, 0), (1, 04DA000B, 0), then one SWITCH cycle with in_ready low, then (0, 00000283, 1); start_signal high one cycle after the last pulse.
REQ-034 Header 00 00 00 00 -> no word_valid pulse, add_into stays 0, start_signal high on the edge after the 4th header byte.
REQ-035 Header 04 01 00 00 (N_I = 1025) -> err high, in_ready low, start_signal low; further bytes ignored.
REQ-036 Header 00 01 00 00, word bytes with in_valid deasserted 3 cycles between each byte -> single pulse with word exactly as sent, addr 0.
REQ-037 Reset low after 2 bytes of the second instruction word, then a fresh 00 01 00 00 + 11223344 -> outputs cleared at reset, single pulse with (0, 11223344, 0), then start_signal high.
